phase_scheduler: RTL and testbench

Intersection phase scheduler that sequences a shared interval timer and arbitrates right-of-way between the highway, the country-road car sensor and a latched pedestrian request. It sits directly beside the traffic-light control path. It owns a 1-second prescaler and an 8-bit seconds down-counter that are reloaded on every phase entry. It drives the two lamp codes, the walk lamp and a seconds-remaining value for the display.

---
 rtl/phase_scheduler_if.sv | 16 +
 rtl/phase_scheduler.sv | 121 ++++++++++++
 tb/tb_phase_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/phase_scheduler_if.sv
// Intersection phase scheduler bus: sensor/button inputs, lamp, state and timer outputs.
interface phase_scheduler_if;
  logic       x;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic       ped_pending;
  logic [2:0] stateD;
  logic [7:0] secs_left;

  modport master (output x, ped_req,
                  input  hwy, cntry, walk, ped_pending, stateD, secs_left);
  modport slave  (input  x, ped_req,
                  output hwy, cntry, walk, ped_pending, stateD, secs_left);
endinterface

// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: highway / country / pedestrian right-of-way with a
// shared 1 s prescaler and 8-bit seconds down-counter reloaded on every phase entry.
module phase_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int HWY_MIN   = 10,
  parameter int YEL_T     = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNTRY_MAX = 15,
  parameter int PED_T     = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  phase_scheduler_if.slave  bus
);

  localparam int              PW_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW_W-1:0] PRE_RELOAD = PW_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    HG = 3'b000, HY = 3'b001, AR1 = 3'b010, CG = 3'b011,
    CY = 3'b100, AR2 = 3'b101, PW = 3'b110, BAD = 3'b111
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      secs_q, secs_d;
  logic [PW_W-1:0] presc_q, presc_d;
  logic            ped_q, ped_d;
  logic            x_q, x_d;
  logic            last_cntry_q, last_cntry_d;
  logic            expired, tick, enter_pw, enter_cg;
  logic [1:0]      hwy_l, cntry_l;
  logic            walk_l;

  function automatic logic [7:0] dur(input state_e s);
    case (s)
      HY, CY:   dur = 8'(YEL_T);
      AR1, AR2: dur = 8'(ALLRED_T);
      CG:       dur = 8'(CNTRY_MAX);
      PW:       dur = 8'(PED_T);
      default:  dur = 8'(HWY_MIN);
    endcase
  endfunction

  assign expired = (secs_q == 8'd0);
  assign tick    = (presc_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:  if (expired && (x_q || ped_q)) state_d = HY;
      HY:  if (expired) state_d = AR1;
      AR1: if (expired) begin
             if (x_q && ped_q) state_d = last_cntry_q ? PW : CG;
             else if (ped_q)   state_d = PW;
             else if (x_q)     state_d = CG;
             else              state_d = HG;
           end
      CG:  if (!x_q || expired) state_d = CY;
      CY:  if (expired) state_d = AR2;
      PW:  if (expired) state_d = AR2;
      AR2: if (expired) state_d = HG;
      default: state_d = HG;
    endcase

    // Any phase change restarts both the prescaler and the seconds counter.
    if (state_d != state_q) begin
      secs_d  = dur(state_d);
      presc_d = PRE_RELOAD;
    end else begin
      presc_d = tick ? PRE_RELOAD : presc_q - 1'b1;
      secs_d  = (tick && !expired) ? secs_q - 8'd1 : secs_q;
    end

    enter_pw     = (state_d == PW) && (state_q != PW);
    enter_cg     = (state_d == CG) && (state_q != CG);
    ped_d        = enter_pw ? 1'b0 : (ped_q | bus.ped_req);
    last_cntry_d = enter_cg ? 1'b1 : (enter_pw ? 1'b0 : last_cntry_q);
    x_d          = bus.x;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= HG;
      secs_q       <= 8'(HWY_MIN);
      presc_q      <= PRE_RELOAD;
      ped_q        <= 1'b0;
      last_cntry_q <= 1'b1;
      x_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      secs_q       <= secs_d;
      presc_q      <= presc_d;
      ped_q        <= ped_d;
      last_cntry_q <= last_cntry_d;
      x_q          <= x_d;
    end
  end

  // Lamp code: G=00, Y=01, R=10.
  always_comb begin
    hwy_l   = 2'b10;
    cntry_l = 2'b10;
    walk_l  = 1'b0;
    case (state_q)
      HG: hwy_l   = 2'b00;
      HY: hwy_l   = 2'b01;
      CG: cntry_l = 2'b00;
      CY: cntry_l = 2'b01;
      PW: walk_l  = 1'b1;
      default: ;
    endcase
  end

  assign bus.hwy         = hwy_l;
  assign bus.cntry       = cntry_l;
  assign bus.walk        = walk_l;
  assign bus.ped_pending = ped_q;
  assign bus.stateD      = state_q;
  assign bus.secs_left   = secs_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: phase-sequence vectors with entry values,
// phase lengths and mid-phase stimulus actions, scored through an expectation queue.
module tb_phase_scheduler;
  localparam int TD = 2, HMIN = 4, YT = 2, ART = 1, CMAX = 5, PT = 3;
  localparam int C_HG = HMIN*TD+1, C_Y = YT*TD+1, C_AR = ART*TD+1;
  localparam int C_CG = CMAX*TD+1, C_PW = PT*TD+1;
  localparam logic [2:0] S_HG = 3'd0, S_HY = 3'd1, S_AR1 = 3'd2, S_CG = 3'd3,
                         S_CY = 3'd4, S_AR2 = 3'd5, S_PW = 3'd6;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   n_chk = 0, n_fail = 0;

  phase_scheduler_if bus();

  phase_scheduler #(.TICK_DIV(TD), .HWY_MIN(HMIN), .YEL_T(YT), .ALLRED_T(ART),
                    .CNTRY_MAX(CMAX), .PED_T(PT))
    dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus.slave));

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit   rs;      // reset (3 cycles) before this phase, released on its first cycle
    bit   rx;      // x level applied with that reset
    logic [2:0] st;
    int   secs;    // secs_left on entry
    int   cyc;     // expected cycles in phase; 0 = check entry only
    bit   pp0;     // ped_pending on first cycle
    bit   ppl;     // ped_pending on last cycle
    int   xa;  bit xv;
    int   pa;  bit pv;
    int   pa2; bit pv2;
    int   ra;  bit rv;
  } vec_t;

  vec_t vec[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lamp_h(input logic [2:0] s);
    return (s == S_HG) ? 0 : (s == S_HY) ? 1 : 2;
  endfunction
  function automatic int lamp_c(input logic [2:0] s);
    return (s == S_CG) ? 0 : (s == S_CY) ? 1 : 2;
  endfunction

  task automatic ph(input bit rs, input bit rx, input logic [2:0] st, input int secs,
                    input int cyc, input bit pp0, input bit ppl);
    vec_t v;
    v = '{default: 0};
    v.rs = rs; v.rx = rx; v.st = st; v.secs = secs; v.cyc = cyc; v.pp0 = pp0; v.ppl = ppl;
    if (rs) begin v.ra = 1; v.rv = 1'b0; end
    vec.push_back(v);
  endtask

  task automatic ax(input int c, input bit val);
    vec[vec.size()-1].xa = c; vec[vec.size()-1].xv = val;
  endtask
  task automatic ap(input int c, input bit val);
    vec[vec.size()-1].pa = c; vec[vec.size()-1].pv = val;
  endtask
  task automatic ap2(input int c, input bit val);
    vec[vec.size()-1].pa2 = c; vec[vec.size()-1].pv2 = val;
  endtask
  task automatic ar(input int c, input bit val);
    vec[vec.size()-1].ra = c; vec[vec.size()-1].rv = val;
  endtask

  task automatic do_act(input vec_t v, input int n);
    if (v.xa == n)  bus.x       = v.xv;
    if (v.pa == n)  bus.ped_req = v.pv;
    if (v.pa2 == n) bus.ped_req = v.pv2;
    if (v.ra == n)  reset       = v.rv;
  endtask

  // Entered at the first negedge of the phase; leaves at the first negedge of the next.
  task automatic run_phase(input int idx, input vec_t v);
    int n;
    bit pp_last;
    string t;
    t = $sformatf("v%0d", idx);
    if (v.rs) begin
      reset = 1'b1; bus.x = v.rx; bus.ped_req = 1'b0;
      repeat (3) @(negedge CLOCK_50);
    end
    chk({t, " state"}, bus.stateD, v.st);
    chk({t, " secs"},  bus.secs_left, v.secs);
    chk({t, " hwy"},   bus.hwy, lamp_h(v.st));
    chk({t, " cntry"}, bus.cntry, lamp_c(v.st));
    chk({t, " walk"},  bus.walk, (v.st == S_PW) ? 1 : 0);
    chk({t, " ped0"},  bus.ped_pending, v.pp0);
    if (v.cyc == 0) return;
    n = 1;
    pp_last = bus.ped_pending;
    do_act(v, 1);
    forever begin
      @(negedge CLOCK_50);
      if (bus.stateD != v.st) break;
      n++;
      pp_last = bus.ped_pending;
      do_act(v, n);
      if (n > 400) break;
    end
    chk({t, " length"},  n, v.cyc);
    chk({t, " pedlast"}, pp_last, v.ppl);
  endtask

  initial begin
    int e;
    reset = 1'b1; bus.x = 1'b0; bus.ped_req = 1'b0;

    // Full cycle with x held: HG, HY, AR1, CG to max, CY, AR2, HG.
    ph(1,1,S_HG,HMIN,C_HG,0,0); ph(0,0,S_HY,YT,C_Y,0,0); ph(0,0,S_AR1,ART,C_AR,0,0);
    ph(0,0,S_CG,CMAX,C_CG,0,0); ph(0,0,S_CY,YT,C_Y,0,0); ph(0,0,S_AR2,ART,C_AR,0,0);
    ph(0,0,S_HG,HMIN,0,0,0);
    // x dropped in CG cycle 3 -> registered at the next edge, CY one edge later.
    ph(1,1,S_HG,HMIN,C_HG,0,0); ph(0,0,S_HY,YT,C_Y,0,0); ph(0,0,S_AR1,ART,C_AR,0,0);
    ph(0,0,S_CG,CMAX,4,0,0); ax(3,0);
    ph(0,0,S_CY,YT,C_Y,0,0); ph(0,0,S_AR2,ART,C_AR,0,0); ph(0,0,S_HG,HMIN,0,0,0);
    // Request withdrawn during HY: AR1 returns to HG.
    ph(1,1,S_HG,HMIN,C_HG,0,0); ph(0,0,S_HY,YT,C_Y,0,0); ax(1,0);
    ph(0,0,S_AR1,ART,C_AR,0,0); ph(0,0,S_HG,HMIN,0,0,0);
    // x plus one-cycle ped pulse: PW wins first tie, then CG.
    ph(1,1,S_HG,HMIN,C_HG,0,1); ap(1,1); ap2(2,0);
    ph(0,0,S_HY,YT,C_Y,1,1); ph(0,0,S_AR1,ART,C_AR,1,1); ph(0,0,S_PW,PT,C_PW,0,0);
    ph(0,0,S_AR2,ART,C_AR,0,0); ph(0,0,S_HG,HMIN,C_HG,0,0); ph(0,0,S_HY,YT,C_Y,0,0);
    ph(0,0,S_AR1,ART,C_AR,0,0); ph(0,0,S_CG,CMAX,0,0,0);
    // ped held across PW entry re-latches; then x+ped alternates CG then PW.
    ph(1,0,S_HG,HMIN,C_HG,0,1); ap(1,1);
    ph(0,0,S_HY,YT,C_Y,1,1); ph(0,0,S_AR1,ART,C_AR,1,1);
    ph(0,0,S_PW,PT,C_PW,0,1); ap(2,0); ax(2,1);
    ph(0,0,S_AR2,ART,C_AR,1,1); ph(0,0,S_HG,HMIN,C_HG,1,1); ph(0,0,S_HY,YT,C_Y,1,1);
    ph(0,0,S_AR1,ART,C_AR,1,1); ph(0,0,S_CG,CMAX,C_CG,1,1); ph(0,0,S_CY,YT,C_Y,1,1);
    ph(0,0,S_AR2,ART,C_AR,1,1); ph(0,0,S_HG,HMIN,C_HG,1,1); ph(0,0,S_HY,YT,C_Y,1,1);
    ph(0,0,S_AR1,ART,C_AR,1,1); ph(0,0,S_PW,PT,0,0,0);
    // One-cycle pulse exactly at the PW entry edge is absorbed.
    ph(1,0,S_HG,HMIN,C_HG,0,1); ap(1,1); ap2(2,0);
    ph(0,0,S_HY,YT,C_Y,1,1); ph(0,0,S_AR1,ART,C_AR,1,1); ap(3,1);
    ph(0,0,S_PW,PT,C_PW,0,0); ap(1,0);
    ph(0,0,S_AR2,ART,C_AR,0,0); ph(0,0,S_HG,HMIN,0,0,0);
    // Reset mid-CG with a pending ped request.
    ph(1,1,S_HG,HMIN,C_HG,0,0); ph(0,0,S_HY,YT,C_Y,0,0); ph(0,0,S_AR1,ART,C_AR,0,0);
    ph(0,0,S_CG,CMAX,3,0,1); ap(1,1); ar(3,1);
    ph(0,0,S_HG,HMIN,C_HG,0,0); ap(1,0); ar(1,0);
    ph(0,0,S_HY,YT,C_Y,0,0); ph(0,0,S_AR1,ART,C_AR,0,0); ph(0,0,S_CG,CMAX,0,0,0);

    // Idle after reset: counts down then parks at 0 in HG.
    repeat (3) @(negedge CLOCK_50);
    chk("rst state", bus.stateD, 0);
    chk("rst hwy",   bus.hwy, 0);
    chk("rst cntry", bus.cntry, 2);
    chk("rst walk",  bus.walk, 0);
    chk("rst secs",  bus.secs_left, HMIN);
    chk("rst ped",   bus.ped_pending, 0);
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      e = HMIN - (c-1)/TD;
      if (e < 0) e = 0;
      chk($sformatf("idle%0d state", c), bus.stateD, 0);
      chk($sformatf("idle%0d secs", c), bus.secs_left, e);
      @(negedge CLOCK_50);
    end

    for (int i = 0; i < vec.size(); i++) begin
      exp_q.push_back(vec[i]);
      run_phase(i, exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
